hack_keyboard: RTL and testbench

HACK_KEYBOARD -- requirements
Module: hack_keyboard

---
 rtl/hack_kbd_pkg.sv | 46 ++++
 rtl/ps2_rx.sv | 125 ++++++++++++
 rtl/hack_keyboard.sv | 114 +++++++++++
 tb/tb_hack_keyboard.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_kbd_pkg.sv
// Shared types and constants for the Hack keyboard controller.
//   rx_state_e : PS/2 receiver FSM state encoding
//   PS2_EXT/BRK: set-2 prefix bytes (extended, break)
//   KEY_*      : Hack special key codes (128-152)
package hack_kbd_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_e;

  localparam logic [BYTE_W-1:0] PS2_EXT = 8'hE0;
  localparam logic [BYTE_W-1:0] PS2_BRK = 8'hF0;

  localparam logic [BYTE_W-1:0] KEY_NONE   = 8'd0;
  localparam logic [BYTE_W-1:0] KEY_ENTER  = 8'd128;
  localparam logic [BYTE_W-1:0] KEY_BKSP   = 8'd129;
  localparam logic [BYTE_W-1:0] KEY_LEFT   = 8'd130;
  localparam logic [BYTE_W-1:0] KEY_UP     = 8'd131;
  localparam logic [BYTE_W-1:0] KEY_RIGHT  = 8'd132;
  localparam logic [BYTE_W-1:0] KEY_DOWN   = 8'd133;
  localparam logic [BYTE_W-1:0] KEY_HOME   = 8'd134;
  localparam logic [BYTE_W-1:0] KEY_END    = 8'd135;
  localparam logic [BYTE_W-1:0] KEY_PGUP   = 8'd136;
  localparam logic [BYTE_W-1:0] KEY_PGDN   = 8'd137;
  localparam logic [BYTE_W-1:0] KEY_INSERT = 8'd138;
  localparam logic [BYTE_W-1:0] KEY_DELETE = 8'd139;
  localparam logic [BYTE_W-1:0] KEY_ESC    = 8'd140;
  localparam logic [BYTE_W-1:0] KEY_F1     = 8'd141;
  localparam logic [BYTE_W-1:0] KEY_F2     = 8'd142;
  localparam logic [BYTE_W-1:0] KEY_F3     = 8'd143;
  localparam logic [BYTE_W-1:0] KEY_F4     = 8'd144;
  localparam logic [BYTE_W-1:0] KEY_F5     = 8'd145;
  localparam logic [BYTE_W-1:0] KEY_F6     = 8'd146;
  localparam logic [BYTE_W-1:0] KEY_F7     = 8'd147;
  localparam logic [BYTE_W-1:0] KEY_F8     = 8'd148;
  localparam logic [BYTE_W-1:0] KEY_F9     = 8'd149;
  localparam logic [BYTE_W-1:0] KEY_F10    = 8'd150;
  localparam logic [BYTE_W-1:0] KEY_F11    = 8'd151;
  localparam logic [BYTE_W-1:0] KEY_F12    = 8'd152;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronizes the raw lines, deframes start/8 data/
// odd parity/stop on ps2_clk falling edges and abandons stalled frames.
//   clk, rst_n   : system clock, async active-low reset
//   ps2_clk_i    : raw PS/2 clock (asynchronous)
//   ps2_data_i   : raw PS/2 data (asynchronous)
//   byte_o       : last accepted byte
//   byte_valid_o : one-cycle pulse when byte_o is freshly accepted
//   frame_err_o  : one-cycle pulse on a discarded frame
module ps2_rx
  import hack_kbd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ps2_clk_i,
  input  logic              ps2_data_i,
  output logic [BYTE_W-1:0] byte_o,
  output logic              byte_valid_o,
  output logic              frame_err_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]        clk_sync_q, data_sync_q;
  logic              clk_prev_q;
  rx_state_e         state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              fall_c, data_c;

  assign fall_c = clk_prev_q & ~clk_sync_q[1];
  assign data_c = data_sync_q[1];

  // Synchronizers and receiver state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
      state_q     <= RX_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      cnt_q       <= '0;
      byte_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      clk_prev_q  <= clk_sync_q[1];
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      cnt_q       <= cnt_d;
      byte_q      <= byte_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  // Next-state: deframing, parity/stop check and stall timeout
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    cnt_d     = cnt_q;
    byte_d    = byte_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;

    if (fall_c || state_q == RX_IDLE) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // This cycle would be the TIMEOUT_CYCLES-th in a row without an edge
    if (state_q != RX_IDLE && !fall_c && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
      state_d = RX_IDLE;
      err_d   = 1'b1;
    end else if (fall_c) begin
      unique case (state_q)
        RX_IDLE: begin
          if (!data_c) begin
            state_d   = RX_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        RX_DATA: begin
          shift_d   = {data_c, shift_q[BYTE_W-1:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
        end
        RX_PARITY: begin
          par_d   = data_c;
          state_d = RX_STOP;
        end
        RX_STOP: begin
          state_d = RX_IDLE;
          if (data_c && (^{shift_q, par_q})) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = valid_q;
  assign frame_err_o  = err_q;

endmodule

// File: rtl/hack_keyboard.sv
// PS/2 set-2 keyboard to Hack key code. Tracks E0/F0 prefixes and holds the
// code of the most recently pressed, still-held key.
//   clk, reset    : system clock, async active-low reset
//   ps2_clk/data  : raw PS/2 lines
//   hack_scancode : Hack code of the held key, 0 when none
//   frame_err     : one-cycle pulse per discarded frame
module hack_keyboard
  import hack_kbd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  output logic [BYTE_W-1:0] hack_scancode,
  output logic              frame_err
);

  logic [BYTE_W-1:0] rx_byte, mapped_c, code_q, code_d;
  logic              rx_valid, rx_err;
  logic              ext_q, ext_d, brk_q, brk_d;

  ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk          (clk),
    .rst_n        (reset),
    .ps2_clk_i    (ps2_clk),
    .ps2_data_i   (ps2_data),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .frame_err_o  (rx_err)
  );

  // Set-2 code (plus extended flag) to Hack code; keypad digits count as digits
  function automatic logic [BYTE_W-1:0] map_code(input logic [BYTE_W-1:0] sc, input logic ext);
    logic [BYTE_W-1:0] hc;
    hc = KEY_NONE;
    if (ext) begin
      case (sc)
        8'h6B: hc = KEY_LEFT;    8'h75: hc = KEY_UP;
        8'h74: hc = KEY_RIGHT;   8'h72: hc = KEY_DOWN;
        8'h6C: hc = KEY_HOME;    8'h69: hc = KEY_END;
        8'h7D: hc = KEY_PGUP;    8'h7A: hc = KEY_PGDN;
        8'h70: hc = KEY_INSERT;  8'h71: hc = KEY_DELETE;
        8'h5A: hc = KEY_ENTER;
        default: hc = KEY_NONE;
      endcase
    end else begin
      case (sc)
        8'h1C: hc = 8'd65; 8'h32: hc = 8'd66; 8'h21: hc = 8'd67; 8'h23: hc = 8'd68;
        8'h24: hc = 8'd69; 8'h2B: hc = 8'd70; 8'h34: hc = 8'd71; 8'h33: hc = 8'd72;
        8'h43: hc = 8'd73; 8'h3B: hc = 8'd74; 8'h42: hc = 8'd75; 8'h4B: hc = 8'd76;
        8'h3A: hc = 8'd77; 8'h31: hc = 8'd78; 8'h44: hc = 8'd79; 8'h4D: hc = 8'd80;
        8'h15: hc = 8'd81; 8'h2D: hc = 8'd82; 8'h1B: hc = 8'd83; 8'h2C: hc = 8'd84;
        8'h3C: hc = 8'd85; 8'h2A: hc = 8'd86; 8'h1D: hc = 8'd87; 8'h22: hc = 8'd88;
        8'h35: hc = 8'd89; 8'h1A: hc = 8'd90;
        8'h45, 8'h70: hc = 8'd48;  8'h16, 8'h69: hc = 8'd49;
        8'h1E, 8'h72: hc = 8'd50;  8'h26, 8'h7A: hc = 8'd51;
        8'h25, 8'h6B: hc = 8'd52;  8'h2E, 8'h73: hc = 8'd53;
        8'h36, 8'h74: hc = 8'd54;  8'h3D, 8'h6C: hc = 8'd55;
        8'h3E, 8'h75: hc = 8'd56;  8'h46, 8'h7D: hc = 8'd57;
        8'h29: hc = 8'd32;       8'h5A: hc = KEY_ENTER;
        8'h66: hc = KEY_BKSP;    8'h76: hc = KEY_ESC;
        8'h05: hc = KEY_F1;  8'h06: hc = KEY_F2;  8'h04: hc = KEY_F3;  8'h0C: hc = KEY_F4;
        8'h03: hc = KEY_F5;  8'h0B: hc = KEY_F6;  8'h83: hc = KEY_F7;  8'h0A: hc = KEY_F8;
        8'h01: hc = KEY_F9;  8'h09: hc = KEY_F10; 8'h78: hc = KEY_F11; 8'h07: hc = KEY_F12;
        default: hc = KEY_NONE;
      endcase
    end
    return hc;
  endfunction

  assign mapped_c = map_code(rx_byte, ext_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      code_q <= KEY_NONE;
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
    end else begin
      code_q <= code_d;
      ext_q  <= ext_d;
      brk_q  <= brk_d;
    end
  end

  // Prefix tracking and make/break hold; a break only releases the held key
  always_comb begin
    code_d = code_q;
    ext_d  = ext_q;
    brk_d  = brk_q;
    if (rx_err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rx_valid) begin
      if (rx_byte == PS2_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == PS2_BRK) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (mapped_c != KEY_NONE) begin
          if (!brk_q) code_d = mapped_c;
          else if (mapped_c == code_q) code_d = KEY_NONE;
        end
      end
    end
  end

  assign hack_scancode = code_q;
  assign frame_err     = rx_err;

endmodule

// File: tb/tb_hack_keyboard.sv
module tb_hack_keyboard;

  localparam int TO   = 200;
  localparam int HALF = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] hack_scancode;
  logic       frame_err;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  int cyc = 0;
  int cyc_fall = 0;

  logic [7:0] obs_sc_pre, obs_sc_post;
  logic       obs_err3, obs_err4;

  // Reference model state
  int  plain_map[int];
  int  ext_map[int];
  int  m_code = 0;
  bit  m_ext = 0, m_brk = 0;

  int letter_sc[26] = '{'h1C,'h32,'h21,'h23,'h24,'h2B,'h34,'h33,'h43,'h3B,'h42,'h4B,'h3A,
                        'h31,'h44,'h4D,'h15,'h2D,'h1B,'h2C,'h3C,'h2A,'h1D,'h22,'h35,'h1A};
  int digit_sc[10]  = '{'h45,'h16,'h1E,'h26,'h25,'h2E,'h36,'h3D,'h3E,'h46};
  int kpad_sc[10]   = '{'h70,'h69,'h72,'h7A,'h6B,'h73,'h74,'h6C,'h75,'h7D};
  int fkey_sc[12]   = '{'h05,'h06,'h04,'h0C,'h03,'h0B,'h83,'h0A,'h01,'h09,'h78,'h07};
  int nav_sc[10]    = '{'h6B,'h75,'h74,'h72,'h6C,'h69,'h7D,'h7A,'h70,'h71};
  int pool_sc[10]   = '{'h1C,'h32,'h75,'h6B,'h29,'h5A,'h16,'h05,'h71,'h14};

  hack_keyboard #(.TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .ps2_clk       (ps2_clk),
    .ps2_data      (ps2_data),
    .hack_scancode (hack_scancode),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (frame_err === 1'b1) err_pulses <= err_pulses + 1;
  end

  task automatic init_maps();
    for (int i = 0; i < 26; i++) plain_map[letter_sc[i]] = 65 + i;
    for (int i = 0; i < 10; i++) begin
      plain_map[digit_sc[i]] = 48 + i;
      plain_map[kpad_sc[i]]  = 48 + i;
      ext_map[nav_sc[i]]     = 130 + i;
    end
    for (int i = 0; i < 12; i++) plain_map[fkey_sc[i]] = 141 + i;
    plain_map['h29] = 32;
    plain_map['h5A] = 128;
    plain_map['h66] = 129;
    plain_map['h76] = 140;
    ext_map['h5A]   = 128;
  endtask

  function automatic int model_map(int b, bit e);
    if (e) return ext_map.exists(b) ? ext_map[b] : 0;
    return plain_map.exists(b) ? plain_map[b] : 0;
  endfunction

  task automatic model_apply(int b);
    int m;
    if (b == 'hE0) m_ext = 1;
    else if (b == 'hF0) m_brk = 1;
    else begin
      m = model_map(b, m_ext);
      if (m != 0) begin
        if (!m_brk) m_code = m;
        else if (m == m_code) m_code = 0;
      end
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic model_discard();
    m_ext = 0;
    m_brk = 0;
  endtask

  task automatic drive_bit(input logic v);
    @(negedge clk) ps2_data = v;
    repeat (HALF - 1) @(negedge clk);
    ps2_clk = 1'b0;
    cyc_fall = cyc;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // Full frame; samples outputs 3 and 4 clk edges after the stop-bit fall
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(par);
    @(negedge clk) ps2_data = ~bad_stop;
    repeat (HALF - 1) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(posedge clk);
    #1 obs_sc_pre = hack_scancode; obs_err3 = frame_err;
    @(posedge clk);
    #1 obs_sc_post = hack_scancode; obs_err4 = frame_err;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    if (bad_par || bad_stop) model_discard();
    else model_apply(int'(b));
  endtask

  task automatic send_partial(input logic [7:0] b, input int n);
    drive_bit(1'b0);
    for (int i = 0; i < n; i++) drive_bit(b[i]);
  endtask

  task automatic good_frame(input logic [7:0] b, input int exp, input string name);
    send_frame(b, 1'b0, 1'b0);
    checks++;
    if (obs_sc_post !== 8'(exp) || obs_err3 !== 1'b0) begin
      errors++;
      $display("FAIL %s: got code %0d err %0b, exp code %0d err 0", name, obs_sc_post, obs_err3, exp);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (hack_scancode !== 8'd0) begin
      errors++; $display("FAIL reset_code: got %0d exp 0", hack_scancode);
    end
    checks++;
    if (frame_err !== 1'b0) begin
      errors++; $display("FAIL reset_err: got %0b exp 0", frame_err);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic();
    send_frame(8'h1C, 1'b0, 1'b0);
    checks++;
    if (obs_sc_pre !== 8'd0) begin
      errors++; $display("FAIL latency_early: got %0d exp 0", obs_sc_pre);
    end
    checks++;
    if (obs_sc_post !== 8'd65) begin
      errors++; $display("FAIL make_A: got %0d exp 65", obs_sc_post);
    end
    good_frame(8'hF0, 65, "prefix_F0_hold");
    good_frame(8'h1C, 0, "break_A");
  endtask

  task automatic test_extended();
    good_frame(8'hE0, 0, "prefix_E0_hold");
    good_frame(8'h75, 131, "make_up");
    good_frame(8'hE0, 131, "ext_brk_E0");
    good_frame(8'hF0, 131, "ext_brk_F0");
    good_frame(8'h75, 0, "break_up");
    good_frame(8'h75, 56, "keypad_8");
    good_frame(8'hF0, 56, "kp8_brk_F0");
    good_frame(8'h75, 0, "break_kp8");
  endtask

  task automatic test_overlap();
    good_frame(8'h1C, 65, "ovl_make_A");
    good_frame(8'h32, 66, "ovl_make_B");
    good_frame(8'hF0, 66, "ovl_F0");
    good_frame(8'h1C, 66, "ovl_break_A_keeps_B");
    good_frame(8'hF0, 66, "ovl_F0b");
    good_frame(8'h32, 0, "ovl_break_B");
    good_frame(8'h12, 0, "shift_ignored");
  endtask

  task automatic test_frame_err();
    good_frame(8'h1C, 65, "perr_setup");
    send_frame(8'h5A, 1'b1, 1'b0);
    checks++;
    if (obs_err3 !== 1'b1 || obs_err4 !== 1'b0) begin
      errors++; $display("FAIL parity_pulse: got %0b%0b exp 10", obs_err3, obs_err4);
    end
    checks++;
    if (obs_sc_post !== 8'd65) begin
      errors++; $display("FAIL parity_hold: got %0d exp 65", obs_sc_post);
    end
    good_frame(8'h5A, 128, "enter_after_perr");
    send_frame(8'h1C, 1'b0, 1'b1);
    checks++;
    if (obs_err3 !== 1'b1 || obs_sc_post !== 8'd128) begin
      errors++; $display("FAIL stop_err: got err %0b code %0d exp err 1 code 128", obs_err3, obs_sc_post);
    end
    good_frame(8'hE0, 128, "flagclr_E0");
    send_frame(8'h33, 1'b1, 1'b0);
    good_frame(8'h75, 56, "flags_cleared_by_err");
  endtask

  task automatic test_timeout();
    int pre, seen;
    pre = err_pulses;
    seen = -1;
    send_partial(8'h5A, 4);
    for (int i = 0; i < TO + 50; i++) begin
      @(posedge clk);
      #1;
      if (frame_err === 1'b1) begin
        seen = cyc - cyc_fall;
        break;
      end
    end
    checks++;
    if (seen < TO + 1 || seen > TO + 5) begin
      errors++; $display("FAIL timeout_delay: got %0d cycles exp about %0d", seen, TO + 3);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (err_pulses - pre !== 1) begin
      errors++; $display("FAIL timeout_pulses: got %0d exp 1", err_pulses - pre);
    end
    checks++;
    if (hack_scancode !== 8'd56) begin
      errors++; $display("FAIL timeout_hold: got %0d exp 56", hack_scancode);
    end
    model_discard();
    good_frame(8'h29, 32, "space_after_timeout");
  endtask

  task automatic test_reset_midframe();
    int pre;
    good_frame(8'h1C, 65, "rst_setup");
    send_partial(8'hAA, 5);
    pre = err_pulses;
    @(negedge clk) reset = 1'b0;
    #1;
    checks++;
    if (hack_scancode !== 8'd0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL rst_mid: got code %0d err %0b exp 0 0", hack_scancode, frame_err);
    end
    m_code = 0;
    model_discard();
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (TO + 20) @(negedge clk);
    checks++;
    if (err_pulses !== pre) begin
      errors++; $display("FAIL rst_no_err: got %0d pulses exp 0", err_pulses - pre);
    end
    good_frame(8'h1C, 65, "post_reset_frame");
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit bp, bs;
    int prev, pre;
    for (int n = 0; n < 70; n++) begin
      case ($urandom_range(0, 9))
        0, 1: b = 8'hE0;
        2, 3: b = 8'hF0;
        4:    b = 8'h12;
        5:    b = 8'($urandom_range(0, 255));
        default: b = 8'(pool_sc[$urandom_range(0, 9)]);
      endcase
      bp = ($urandom_range(0, 9) == 0);
      bs = !bp && ($urandom_range(0, 14) == 0);
      prev = m_code;
      pre = err_pulses;
      send_frame(b, bp, bs);
      checks++;
      if (obs_sc_pre !== 8'(prev) || obs_sc_post !== 8'(m_code)) begin
        errors++;
        $display("FAIL rand_code[%0d] byte %02h: got %0d->%0d exp %0d->%0d", n, b, obs_sc_pre, obs_sc_post, prev, m_code);
      end
      checks++;
      if (err_pulses - pre !== int'(bp || bs)) begin
        errors++;
        $display("FAIL rand_err[%0d] byte %02h: got %0d pulses exp %0d", n, b, err_pulses - pre, int'(bp || bs));
      end
    end
  endtask

  initial begin
    init_maps();
    test_reset();
    test_basic();
    test_extended();
    test_overlap();
    test_frame_err();
    test_timeout();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
